// File: rtl/io_mmio_if.sv
// rtl/io_mmio_if.sv - CPU-side IO bus and UART byte handshakes for io_mmio
// Purpose: bundles the load/store bus from MemControl and the UART TX/RX
//          byte handshakes into one interface.
// Modports:
//   slave  - io_mmio side: takes A, Io_trans, Io_recv, WriteData, InstrValid,
//            UARTTxDataInReady, UARTRxDataOutValid, UARTRxDataOut;
//            drives IoReadData, UARTTxDataInValid, UARTTxDataIn,
//            UARTRxDataOutReady.
//   master - CPU/UART side, the same signals in the opposite directions.
interface io_mmio_if;
  logic [31:0] A;
  logic [3:0]  Io_trans;
  logic        Io_recv;
  logic [31:0] WriteData;
  logic        InstrValid;
  logic [31:0] IoReadData;
  logic        UARTTxDataInValid;
  logic [7:0]  UARTTxDataIn;
  logic        UARTTxDataInReady;
  logic        UARTRxDataOutValid;
  logic [7:0]  UARTRxDataOut;
  logic        UARTRxDataOutReady;

  modport slave (
    input  A, Io_trans, Io_recv, WriteData, InstrValid,
    input  UARTTxDataInReady, UARTRxDataOutValid, UARTRxDataOut,
    output IoReadData, UARTTxDataInValid, UARTTxDataIn, UARTRxDataOutReady
  );

  modport master (
    output A, Io_trans, Io_recv, WriteData, InstrValid,
    output UARTTxDataInReady, UARTRxDataOutValid, UARTRxDataOut,
    input  IoReadData, UARTTxDataInValid, UARTTxDataIn, UARTRxDataOutReady
  );
endinterface

// File: rtl/io_mmio.sv
// rtl/io_mmio.sv - memory-mapped IO block: UART TX/RX registers and counters
// Purpose: decodes CPU IO loads/stores on A[7:2] into a UART status register,
//          an RX data port, a 1-entry TX holding register and two optional
//          32-bit counters (cycles, retired instructions).
// Ports:
//   Clock - system clock
//   Reset - synchronous, active-high reset
//   bus   - io_mmio_if.slave (address/data/strobes, UART TX/RX handshakes)
// Configuration:
//   IO_COUNTERS_EN - when defined, builds the cycle and instruction counters
//                    (0x10/0x14, cleared by any write to 0x18). When
//                    undefined, 0x10/0x14 read 0 and 0x18 writes do nothing.
module io_mmio (
  input logic       Clock,
  input logic       Reset,
  io_mmio_if.slave  bus
);

  localparam logic [5:0] OFF_STATUS = 6'h00; // 0x00
  localparam logic [5:0] OFF_RXDATA = 6'h01; // 0x04
  localparam logic [5:0] OFF_TXDATA = 6'h02; // 0x08
  localparam logic [5:0] OFF_CYCLE  = 6'h04; // 0x10
  localparam logic [5:0] OFF_INSTR  = 6'h05; // 0x14
  localparam logic [5:0] OFF_CLEAR  = 6'h06; // 0x18

  typedef enum logic {TX_IDLE = 1'b0, TX_FULL = 1'b1} tx_state_t;

  tx_state_t   r_tx_state;
  logic [7:0]  r_tx_data;
  logic [31:0] r_rdata;

  logic [5:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_load;
  logic [31:0] w_rdata;
  logic [31:0] w_cycle;
  logic [31:0] w_instr;

  assign w_off = bus.A[7:2];
  // Bus strobes are masked by Reset so nothing is decoded while in reset.
  assign w_wr  = !Reset && (bus.Io_trans != 4'b0000);
  assign w_rd  = !Reset && bus.Io_recv;

  // A TX load is only accepted in IDLE; the emptying handshake only happens
  // in FULL, so the two can never coincide.
  assign w_tx_load = w_wr && (w_off == OFF_TXDATA) && bus.Io_trans[0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_load) begin
            r_tx_data  <= bus.WriteData[7:0];
            r_tx_state <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (bus.UARTTxDataInReady) begin
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.UARTTxDataInValid = (r_tx_state == TX_FULL);
  assign bus.UARTTxDataIn      = r_tx_data;

  // Consume the RX byte in the same cycle as the load that captures it.
  assign bus.UARTRxDataOutReady = w_rd && (w_off == OFF_RXDATA) && bus.UARTRxDataOutValid;

`ifdef IO_COUNTERS_EN
  logic [31:0] r_cyc;
  logic [31:0] r_instr;
  logic        w_clear;

  assign w_clear = w_wr && (w_off == OFF_CLEAR);

  always_ff @(posedge Clock) begin
    if (Reset || w_clear) begin
      r_cyc   <= 32'h0;
      r_instr <= 32'h0;
    end else begin
      r_cyc <= r_cyc + 32'h1;
      if (bus.InstrValid) begin
        r_instr <= r_instr + 32'h1;
      end
    end
  end

  assign w_cycle = r_cyc;
  assign w_instr = r_instr;
`else
  assign w_cycle = 32'h0;
  assign w_instr = 32'h0;
`endif

  // Read mux sees the pre-update register values, so a counter read returns
  // its value before any same-cycle increment or clear.
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_STATUS: w_rdata = {30'h0, bus.UARTRxDataOutValid, (r_tx_state == TX_IDLE)};
      OFF_RXDATA: w_rdata = {24'h0, bus.UARTRxDataOut};
      OFF_CYCLE:  w_rdata = w_cycle;
      OFF_INSTR:  w_rdata = w_instr;
      default:    w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rdata <= 32'h0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.IoReadData = r_rdata;

  // Address bits outside the decode window and the upper store data bits are
  // intentionally ignored.
  logic w_unused;
  assign w_unused = ^{bus.A[31:8], bus.A[1:0], bus.WriteData[31:8], bus.InstrValid};

endmodule

// File: tb/tb_io_mmio.sv
// tb/tb_io_mmio.sv - directed self-checking bench for io_mmio
module tb_io_mmio;
  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  io_mmio_if bus ();

  io_mmio dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.A         = 32'h0;
    bus.Io_trans  = 4'h0;
    bus.Io_recv   = 1'b0;
    bus.WriteData = 32'h0;
    bus.InstrValid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus.A = addr; bus.WriteData = data; bus.Io_trans = mask; bus.Io_recv = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [31:0] addr);
    bus.A = addr; bus.Io_recv = 1'b1; bus.Io_trans = 4'h0;
    tick();
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    bus.UARTTxDataInReady  = 1'b0;
    bus.UARTRxDataOutValid = 1'b0;
    bus.UARTRxDataOut      = 8'h00;
    tick();
    tick();
    check("rst_valid", {31'h0, bus.UARTTxDataInValid}, 32'h0);
    check("rst_txdata", {24'h0, bus.UARTTxDataIn}, 32'h0);
    check("rst_rdata", bus.IoReadData, 32'h0);

    // RX read during reset: no ready pulse, no capture
    bus.UARTRxDataOutValid = 1'b1; bus.UARTRxDataOut = 8'hA5;
    bus.A = 32'h4; bus.Io_recv = 1'b1;
    #1;
    check("rst_rxready", {31'h0, bus.UARTRxDataOutReady}, 32'h0);
    tick();
    idle();
    check("rst_read_ignored", bus.IoReadData, 32'h0);
    bus.UARTRxDataOutValid = 1'b0; bus.UARTRxDataOut = 8'h00;
    Reset = 1'b0;
    tick();

    do_read(32'h0);
    check("status_idle", bus.IoReadData, 32'h1);

    // TX load then status shows not ready
    do_write(32'h8, 32'h0000_0041, 4'b0001);
    check("tx_valid_load", {31'h0, bus.UARTTxDataInValid}, 32'h1);
    check("tx_data_load", {24'h0, bus.UARTTxDataIn}, 32'h41);
    do_read(32'h0);
    check("status_full", bus.IoReadData, 32'h0);

    // write while FULL is dropped
    do_write(32'h8, 32'h0000_0042, 4'b0001);
    check("tx_drop_data", {24'h0, bus.UARTTxDataIn}, 32'h41);
    check("tx_drop_valid", {31'h0, bus.UARTTxDataInValid}, 32'h1);
    bus.UARTTxDataInReady = 1'b1;
    tick();
    bus.UARTTxDataInReady = 1'b0;
    check("tx_drained", {31'h0, bus.UARTTxDataInValid}, 32'h0);
    do_read(32'h0);
    check("status_drained", bus.IoReadData, 32'h1);

    // byte lane 0 not enabled: ignored
    do_write(32'h8, 32'h0000_0077, 4'b0010);
    check("tx_lane_ignored", {31'h0, bus.UARTTxDataInValid}, 32'h0);

    // upper and low address bits ignored
    do_write(32'h1234_5609, 32'hFFFF_FF99, 4'b0001);
    check("tx_alias_valid", {31'h0, bus.UARTTxDataInValid}, 32'h1);
    check("tx_alias_data", {24'h0, bus.UARTTxDataIn}, 32'h99);
    bus.UARTTxDataInReady = 1'b1;
    tick();
    bus.UARTTxDataInReady = 1'b0;

    // RX read with valid byte
    bus.UARTRxDataOutValid = 1'b1; bus.UARTRxDataOut = 8'h5A;
    bus.A = 32'h4; bus.Io_recv = 1'b1;
    #1;
    check("rx_ready_pulse", {31'h0, bus.UARTRxDataOutReady}, 32'h1);
    tick();
    idle();
    #1;
    check("rx_ready_drop", {31'h0, bus.UARTRxDataOutReady}, 32'h0);
    check("rx_data", bus.IoReadData, 32'h0000_005A);
    tick();
    check("rdata_hold", bus.IoReadData, 32'h0000_005A);

    // RX read without valid: data returned, no pulse
    bus.UARTRxDataOutValid = 1'b0; bus.UARTRxDataOut = 8'h33;
    bus.A = 32'h4; bus.Io_recv = 1'b1;
    #1;
    check("rx_noready", {31'h0, bus.UARTRxDataOutReady}, 32'h0);
    tick();
    idle();
    check("rx_data_novalid", bus.IoReadData, 32'h33);

    bus.UARTRxDataOutValid = 1'b1;
    do_read(32'h0);
    check("status_rx_valid", bus.IoReadData, 32'h3);
    bus.UARTRxDataOutValid = 1'b0;
    do_read(32'h8);
    check("read_tx_zero", bus.IoReadData, 32'h0);
    do_read(32'h0);
    do_read(32'hC);
    check("read_unmapped", bus.IoReadData, 32'h0);
    do_read(32'h0);
    do_read(32'h18);
    check("read_clear_zero", bus.IoReadData, 32'h0);

    // simultaneous write and read
    do_read(32'h0);
    bus.A = 32'h8; bus.WriteData = 32'h55; bus.Io_trans = 4'b0001; bus.Io_recv = 1'b1;
    tick();
    idle();
    check("wr_rd_rdata", bus.IoReadData, 32'h0);
    check("wr_rd_txdata", {24'h0, bus.UARTTxDataIn}, 32'h55);
    check("wr_rd_valid", {31'h0, bus.UARTTxDataInValid}, 32'h1);

`ifdef IO_COUNTERS_EN
    do_write(32'h18, 32'h0, 4'b1111);
    do_read(32'h10);
    check("cyc_after_clear", bus.IoReadData, 32'h0);
    bus.InstrValid = 1'b1;
    tick(); tick(); tick();
    bus.InstrValid = 1'b0;
    do_read(32'h14);
    check("instr_count", bus.IoReadData, 32'h3);
    bus.A = 32'h18; bus.Io_trans = 4'b0001; bus.InstrValid = 1'b1;
    tick();
    idle();
    do_read(32'h14);
    check("instr_clear_prio", bus.IoReadData, 32'h0);
    do_read(32'h10);
    check("cyc_clear_prio", bus.IoReadData, 32'h1);
    @(negedge Clock);
    force dut.r_cyc = 32'hFFFF_FFFE;
    #1;
    release dut.r_cyc;
    @(posedge Clock); #1;
    do_read(32'h10);
    check("cyc_max", bus.IoReadData, 32'hFFFF_FFFF);
    do_read(32'h10);
    check("cyc_wrap", bus.IoReadData, 32'h0);
    bus.InstrValid = 1'b1;
    tick();
    bus.InstrValid = 1'b0;
`else
    do_read(32'h0);
    do_read(32'h10);
    check("cyc_absent", bus.IoReadData, 32'h0);
    do_read(32'h0);
    do_read(32'h14);
    check("instr_absent", bus.IoReadData, 32'h0);
`endif

    // reset while TX FULL, with a write attempted during reset
    do_read(32'h0);
    Reset = 1'b1;
    bus.A = 32'h8; bus.WriteData = 32'h66; bus.Io_trans = 4'b0001;
    tick();
    idle();
    check("rst_full_valid", {31'h0, bus.UARTTxDataInValid}, 32'h0);
    check("rst_full_txdata", {24'h0, bus.UARTTxDataIn}, 32'h0);
    check("rst_full_rdata", bus.IoReadData, 32'h0);
    Reset = 1'b0;
    do_read(32'h10);
    check("rst_cyc_zero", bus.IoReadData, 32'h0);
    check("rst_no_load", {31'h0, bus.UARTTxDataInValid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
